// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM pipeline register: ARM condition codes, NZVC flags, XZR.
package ex_mem_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM stage bundle: EX-side instruction fields in, registered MEM fields, flags and forwarding out.
interface ex_mem_if;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_setFlags;
    logic [63:0] ex_result;
    logic [63:0] ex_storeData;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_cond;
    logic        ex_isBcond;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic        mem_valid;
    logic        mem_RegWrite;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [63:0] mem_result;
    logic [63:0] mem_storeData;
    logic [4:0]  mem_rd;
    logic [3:0]  flags_q;
    logic        br_taken;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;

    modport master (
        output stall, flush, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_setFlags,
               ex_result, ex_storeData, ex_rd, ex_cond, ex_isBcond,
               negative, zero, overflow, carry_out,
        input  mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_result, mem_storeData,
               mem_rd, flags_q, br_taken, fwd_en, fwd_rd, fwd_data
    );

    modport slave (
        input  stall, flush, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_setFlags,
               ex_result, ex_storeData, ex_rd, ex_cond, ex_isBcond,
               negative, zero, overflow, carry_out,
        output mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_result, mem_storeData,
               mem_rd, flags_q, br_taken, fwd_en, fwd_rd, fwd_data
    );
endinterface

// File: rtl/ex_mem_stage_cond_check.sv
// Combinational ARM condition-code evaluation against an NZVC flag set.
module cond_check
    import ex_mem_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   true
);

    always_comb begin
        true = 1'b1;
        case (cond)
            COND_EQ: true = flags.z;
            COND_NE: true = !flags.z;
            COND_HS: true = flags.c;
            COND_LO: true = !flags.c;
            COND_MI: true = flags.n;
            COND_PL: true = !flags.n;
            COND_VS: true = flags.v;
            COND_VC: true = !flags.v;
            COND_HI: true = flags.c & !flags.z;
            COND_LS: true = !flags.c | flags.z;
            COND_GE: true = (flags.n == flags.v);
            COND_LT: true = (flags.n != flags.v);
            COND_GT: true = !flags.z & (flags.n == flags.v);
            COND_LE: true = flags.z | (flags.n != flags.v);
            default: true = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with NZVC flag register, B.cond resolution and MEM-side forwarding.
// Define FLAG_BYPASS_EN to let a flag-setting EX instruction feed its own flags to B.cond.
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    ex_mem_if.slave  bus
);

    logic        mem_valid;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [63:0] mem_result;
    logic [63:0] mem_store_data;
    logic [4:0]  mem_rd;
    flags_t      flags_q;
    flags_t      ex_flags;
    flags_t      flag_src;
    logic        cond_ok;

    assign ex_flags = {bus.negative, bus.zero, bus.overflow, bus.carry_out};

    // Flush only kills the control bits; data registers just hold since they are don't-care in a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            flags_q        <= '0;
        end else if (bus.flush) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
        end else if (!bus.stall) begin
            mem_valid      <= bus.ex_valid;
            mem_reg_write  <= bus.ex_valid & bus.ex_RegWrite & (bus.ex_rd != XZR);
            mem_mem_read   <= bus.ex_valid & bus.ex_MemRead;
            mem_mem_write  <= bus.ex_valid & bus.ex_MemWrite;
            mem_result     <= bus.ex_result;
            mem_store_data <= bus.ex_storeData;
            mem_rd         <= bus.ex_rd;
            if (bus.ex_valid & bus.ex_setFlags)
                flags_q <= ex_flags;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign flag_src = (bus.ex_valid & bus.ex_setFlags) ? ex_flags : flags_q;
`else
    assign flag_src = flags_q;
`endif

    cond_check u_cond_check (
        .cond  (cond_e'(bus.ex_cond)),
        .flags (flag_src),
        .true  (cond_ok)
    );

    assign bus.br_taken      = bus.ex_valid & bus.ex_isBcond & cond_ok;
    assign bus.mem_valid     = mem_valid;
    assign bus.mem_RegWrite  = mem_reg_write;
    assign bus.mem_MemRead   = mem_mem_read;
    assign bus.mem_MemWrite  = mem_mem_write;
    assign bus.mem_result    = mem_result;
    assign bus.mem_storeData = mem_store_data;
    assign bus.mem_rd        = mem_rd;
    assign bus.flags_q       = flags_q;
    assign bus.fwd_en        = mem_valid & mem_reg_write;
    assign bus.fwd_rd        = mem_rd;
    assign bus.fwd_data      = mem_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed scenarios then randomized traffic against a behavioural model.
module tb_ex_mem_stage;

    typedef struct {
        bit        valid, rw, mr, mw, sf, isb, stall, flush;
        bit [3:0]  cond;
        bit [4:0]  rd;
        bit [63:0] res, sd;
        bit        n, z, v, c;
    } stim_t;

    typedef struct {
        bit        valid, rw, mr, mw;
        bit        data_known;
        bit [4:0]  rd;
        bit [63:0] res, sd;
        bit [3:0]  flags;
    } model_t;

    typedef struct {
        model_t st;
        bit     br;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;

    ex_mem_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    model_t model;
    stim_t  prevStim;
    exp_t   scoreboard[$];

    function automatic stim_t blankStim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Condition codes come in complementary pairs: the odd code inverts the even one, 14/15 always hold.
    function automatic bit condRef(bit [3:0] code, bit [3:0] f);
        bit n, z, v, c, base;
        {n, z, v, c} = f;
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    task automatic modelEdge(input stim_t s);
        if (s.flush) begin
            model.valid = 0; model.rw = 0; model.mr = 0; model.mw = 0;
            model.data_known = 0;
        end else if (!s.stall) begin
            model.valid = s.valid;
            model.rw    = s.valid && s.rw && (s.rd != 5'd31);
            model.mr    = s.valid && s.mr;
            model.mw    = s.valid && s.mw;
            model.rd    = s.rd;
            model.res   = s.res;
            model.sd    = s.sd;
            model.data_known = 1;
            if (s.valid && s.sf) model.flags = {s.n, s.z, s.v, s.c};
        end
    endtask

    task automatic modelReset();
        model = '{default: '0};
        model.data_known = 1;
    endtask

    task automatic driveInputs(input stim_t s);
        bus.stall = s.stall;          bus.flush = s.flush;
        bus.ex_valid = s.valid;       bus.ex_RegWrite = s.rw;
        bus.ex_MemRead = s.mr;        bus.ex_MemWrite = s.mw;
        bus.ex_setFlags = s.sf;       bus.ex_isBcond = s.isb;
        bus.ex_cond = s.cond;         bus.ex_rd = s.rd;
        bus.ex_result = s.res;        bus.ex_storeData = s.sd;
        bus.negative = s.n;           bus.zero = s.z;
        bus.overflow = s.v;           bus.carry_out = s.c;
    endtask

    task automatic pushExpect(input stim_t s);
        exp_t e;
        bit [3:0] f;
        f = model.flags;
`ifdef FLAG_BYPASS_EN
        if (s.valid && s.sf) f = {s.n, s.z, s.v, s.c};
`endif
        e.st = model;
        e.br = s.valid && s.isb && condRef(s.cond, f);
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        modelEdge(prevStim);
        #1;
        driveInputs(s);
        prevStim = s;
        pushExpect(s);
    endtask

    // Reset is pulsed between edges, so the next negedge sample must already see cleared state.
    task automatic applyReset();
        @(posedge clk);
        modelEdge(prevStim);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        modelReset();
        pushExpect(prevStim);
    endtask

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] expv);
        testsRun++;
        if (act !== expv) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare("mem_valid",    64'(bus.mem_valid),    64'(e.st.valid));
        compare("mem_RegWrite", 64'(bus.mem_RegWrite), 64'(e.st.rw));
        compare("mem_MemRead",  64'(bus.mem_MemRead),  64'(e.st.mr));
        compare("mem_MemWrite", 64'(bus.mem_MemWrite), 64'(e.st.mw));
        compare("fwd_en",       64'(bus.fwd_en),       64'(e.st.valid && e.st.rw));
        compare("flags_q",      64'(bus.flags_q),      64'(e.st.flags));
        compare("br_taken",     64'(bus.br_taken),     64'(e.br));
        if (e.st.data_known) begin
            compare("mem_rd",        64'(bus.mem_rd),  64'(e.st.rd));
            compare("fwd_rd",        64'(bus.fwd_rd),  64'(e.st.rd));
            compare("mem_result",    bus.mem_result,   e.st.res);
            compare("fwd_data",      bus.fwd_data,     e.st.res);
            compare("mem_storeData", bus.mem_storeData, e.st.sd);
        end
    endtask

    // Monitor: every expectation queued by the driver is checked at the following falling edge.
    always @(negedge clk) begin
        if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
    end

    initial begin
        stim_t s;
        prevStim = blankStim();
        modelReset();
        driveInputs(prevStim);
        #3 reset = 1'b0;

        applyStimulus(blankStim());

        s = blankStim(); s.valid = 1; s.rw = 1; s.rd = 5'd5; s.res = 64'h1234; s.sd = 64'hABCD;
        applyStimulus(s);
        s = blankStim(); s.valid = 1; s.rw = 1; s.rd = 5'd31; s.res = 64'h55;
        applyStimulus(s);
        s = blankStim(); s.valid = 1; s.rw = 1; s.sf = 1; s.n = 1; s.rd = 5'd2; s.res = 64'hFFFF_FFFF_FFFF_FFF0;
        applyStimulus(s);
        s = blankStim(); s.valid = 1; s.isb = 1; s.cond = 4'd11;
        applyStimulus(s);
        s = blankStim(); s.valid = 1; s.isb = 1; s.cond = 4'd10;
        applyStimulus(s);

        for (int i = 0; i < 3; i++) begin
            s = blankStim(); s.stall = 1; s.valid = 1; s.rw = 1; s.sf = 1; s.mw = 1;
            s.rd = 5'(i + 7); s.res = 64'(i + 100); s.sd = 64'(i + 200); s.z = 1; s.c = 1;
            applyStimulus(s);
        end
        s.flush = 1;
        applyStimulus(s);
        applyStimulus(blankStim());

        s = blankStim(); s.valid = 1; s.rw = 1; s.sf = 1; s.z = 1; s.v = 1; s.rd = 5'd9; s.res = 64'h77;
        applyStimulus(s);
        s.sf = 0; s.z = 0; s.v = 0;
        applyStimulus(s);
        applyReset();
        s = blankStim(); s.valid = 1; s.sf = 1; s.z = 1; s.isb = 1; s.cond = 4'd0;
        applyStimulus(s);

        for (int i = 0; i < 400; i++) begin
            s.valid = ($urandom_range(0, 7) != 0);
            s.rw = $urandom; s.mr = $urandom; s.mw = $urandom;
            s.sf = $urandom; s.isb = $urandom;
            s.stall = ($urandom_range(0, 4) == 0);
            s.flush = ($urandom_range(0, 7) == 0);
            s.cond = 4'($urandom);
            s.rd = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
            s.res = {$urandom, $urandom};
            s.sd = {$urandom, $urandom};
            {s.n, s.z, s.v, s.c} = 4'($urandom);
            if (i % 97 == 50) applyReset();
            else applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        compare("scoreboard_drained", 64'(scoreboard.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
